// File: rtl/sum_accumulator64.sv
// sum_accumulator64: 64-bit streaming accumulator with sticky carry and saturating operand count
// Ports:
//     clk       in   1      rising-edge clock
//     rst_n     in   1      synchronous active-low reset
//     clr       in   1      synchronous clear of the accumulation, highest priority after reset
//     in_valid  in   1      operand valid
//     in_ready  out  1      operand can be accepted (IDLE/ACCUM, not in reset)
//     in_data   in   64     unsigned operand
//     in_last   in   1      final operand of the group
//     out_valid out  1      result presented (DONE)
//     out_ready in   1      downstream accepts result
//     out_sum   out  64     accumulated sum (acc register)
//     out_carry out  1      sticky OR of adder carry-outs in the group
//     out_count out  CNT_W  operands accepted in the group, saturating
// Config: define SUM_ACCUMULATOR_SATURATE_EN to clamp acc to all-ones on carry-out instead of wrapping.

module RippleCarryAdder64 (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [64:0] w_c;
    assign w_c[0] = cin;
    for (genvar i = 0; i < 64; i++) begin : g_fa
        assign sum[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    assign cout = w_c[64];
endmodule

module sum_accumulator64 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [63:0]      r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_take;
    logic [63:0]      w_acc_next;

    RippleCarryAdder64 u_add (
        .A    (r_acc),
        .B    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    assign w_acc_next = w_cout ? 64'hFFFF_FFFF_FFFF_FFFF : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    assign in_ready  = rst_n && (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_acc;
    assign out_carry = r_carry;
    assign out_count = r_count;
    assign w_accept  = in_valid && in_ready && !clr;
    assign w_take    = out_valid && out_ready;

    always_comb begin
        w_next = r_state;
        if (clr || w_take)
            w_next = IDLE;
        else if (w_accept)
            w_next = in_last ? DONE : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (clr || w_take) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_count <= '0;
            end else if (w_accept) begin
                r_acc   <= w_acc_next;
                r_carry <= r_carry | w_cout;
                r_count <= (&r_count) ? r_count : r_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sum_accumulator64.sv
// tb_sum_accumulator64: directed scoreboard bench for sum_accumulator64 (CNT_W=2)
module tb_sum_accumulator64;
    localparam int CNT_W = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0]      s;
        logic             c;
        logic [CNT_W-1:0] n;
    } exp_t;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             clr = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [63:0]      in_data = '0;
    logic             in_last = 0;
    logic             out_valid;
    logic             out_ready = 1;
    logic [63:0]      out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    sum_accumulator64 #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", out_sum, e.s);
                check("carry", 64'(out_carry), 64'(e.c));
                check("count", 64'(out_count), 64'(e.n));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic last);
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic expect_result(input logic [63:0] s, input logic c, input logic [CNT_W-1:0] n);
        exp_t e;
        e.s = s;
        e.c = c;
        e.n = n;
        q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_sum"}, out_sum, 64'(0));
        check({tag, "_carry"}, 64'(out_carry), 64'(0));
        check({tag, "_count"}, 64'(out_count), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        step();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        step();
        rst_n = 1;
        check_zero("reset");

        expect_result(64'h0000_0001_0000_0000, 1'b0, 2'd2);
        send(64'h0000_0000_FFFF_FFFF, 1'b0);
        send(64'h1, 1'b1);
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'(1));
        check("done_in_ready", 64'(in_ready), 64'(0));
        step();

`ifdef SUM_ACCUMULATOR_SATURATE_EN
        expect_result(ONES, 1'b1, 2'd2);
`else
        expect_result(64'h0, 1'b1, 2'd2);
`endif
        send(ONES, 1'b0);
        send(64'h1, 1'b1);
        step();

        out_ready = 0;
        expect_result(64'd7, 1'b0, 2'd2);
        send(64'd3, 1'b0);
        send(64'd4, 1'b1);
        in_valid = 1;
        in_data  = 64'd99;
        in_last  = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_sum", out_sum, 64'd7);
            check("bp_count", 64'(out_count), 64'(2));
            step();
        end
        in_valid  = 0;
        in_last   = 0;
        out_ready = 1;
        step();
        check_zero("after_bp");

        send(64'd10, 1'b0);
        clr      = 1;
        in_valid = 1;
        in_data  = 64'd5;
        step();
        clr      = 0;
        in_valid = 0;
        check_zero("clr");
        expect_result(64'd7, 1'b0, 2'd1);
        send(64'd7, 1'b1);
        step();

        send(ONES, 1'b0);
        send(64'd2, 1'b0);
        @(negedge clk);
        check("mid_carry", 64'(out_carry), 64'(1));
        rst_n = 0;
        step();
        rst_n = 1;
        check_zero("mid_reset");

        expect_result(64'd5, 1'b0, 2'd3);
        for (int k = 0; k < 4; k++) send(64'h1, 1'b0);
        send(64'h1, 1'b1);
        step();

        out_ready = 0;
        send(64'd8, 1'b1);
        clr = 1;
        step();
        clr = 0;
        out_ready = 1;
        check_zero("clr_done");

        expect_result(64'd600, 1'b0, 2'd3);
        send(64'd100, 1'b0);
        send(64'd200, 1'b0);
        send(64'd300, 1'b1);
        step();
        step();

        check("queue_drained", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sum_accumulator64.md
SUM_ACCUMULATOR64 -- requirements
Module: sum_accumulator64

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, width of the accepted-operand counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: clr  input  1  synchronous clear of the accumulation, active-high.
REQ-005 SHALL have port: in_valid  input  1  operand valid.
REQ-006 SHALL have port: in_ready  output  1  operand can be accepted.
REQ-007 SHALL have port: in_data  input  64  unsigned operand.
REQ-008 SHALL have port: in_last  input  1  marks the final operand of a group, sampled with in_data.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port: out_sum  output  64  accumulated sum, driven from the acc register.
REQ-012 SHALL have port: out_carry  output  1  sticky OR of every adder carry-out in the group.
REQ-013 SHALL have port: out_count  output  CNT_W  operands accepted in the group.

Function
REQ-014 SHALL compute acc + in_data with one instance of RippleCarryAdder64: A=acc, B=in_data, cin=0. Sum and cout are registered; no combinational path exists from the adder to any output.
REQ-015 SHALL implement states IDLE (no operand yet), ACCUM (one or more operands held) and DONE (result presented).
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE and while rst_n=0.
REQ-017 SHALL accept an operand on a rising edge when in_valid=1, in_ready=1 and clr=0. On acceptance, on the same edge: acc<=sum; out_carry<=out_carry|cout; out_count<=out_count+1.
REQ-018 SHALL move IDLE->ACCUM when a non-last operand is accepted, and IDLE/ACCUM->DONE when an operand with in_last=1 is accepted; result latency is 1 cycle after the last accept.
REQ-019 SHALL drive out_valid=1 only in DONE. out_sum, out_carry and out_count SHALL hold stable until out_valid=1 and out_ready=1 on the same edge.
REQ-020 SHALL, on the DONE handshake, go to IDLE with acc=0, out_carry=0, out_count=0; in_ready=1 on the following cycle (no same-cycle accept in DONE).
REQ-021 SHALL saturate out_count at 2^CNT_W-1; further accepts still add.
REQ-022 SHALL ignore in_valid, in_data and in_last while in DONE.
REQ-023 SHALL, when clr=1 at an edge in any state, go to IDLE, clear acc, out_carry and out_count, deassert out_valid, and drop any simultaneous operand. clr SHALL have priority over both handshakes.
REQ-024 SHALL wrap acc modulo 2^64 on carry-out when SATURATE_EN is undefined.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, set state=IDLE, acc=0, out_carry=0, out_count=0 and out_valid=0. This holds from any state, including mid-group and DONE.
REQ-026 SHALL give rst_n priority over clr and over both handshakes.

Configuration
REQ-027 SHALL, with SUM_ACCUMULATOR_SATURATE_EN defined, load acc with 64'hFFFF_FFFF_FFFF_FFFF on any accepted add whose cout=1. acc stays all-ones for the rest of the group, and out_carry is set.
REQ-028 SHALL, without SUM_ACCUMULATOR_SATURATE_EN, wrap per REQ-024; out_carry behaviour is identical in both builds.

Verification
REQ-029 SHALL cover carry across 32 bits: 64'h00000000FFFFFFFF (last=0) then 64'h1 (last=1) -> out_valid one cycle later; out_sum=64'h0000000100000000, out_carry=0, out_count=2.
REQ-030 SHALL cover overflow: 64'hFFFFFFFFFFFFFFFF then 64'h1 (last=1) -> out_sum=0 and out_carry=1 without the macro; out_sum=64'hFFFFFFFFFFFFFFFF and out_carry=1 with it.
REQ-031 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 -> out_valid=1, in_ready=0, outputs unchanged. out_ready=1 then gives IDLE next cycle with out_count=0.
REQ-032 SHALL cover clear priority: clr=1 and in_valid=1 (in_data=5) on the same edge in ACCUM -> next cycle IDLE, acc=0, operand lost; then 7 (last=1) gives out_sum=7, out_count=1.
REQ-033 SHALL cover reset mid-group: rst_n=0 for one edge after two accepts -> all outputs zero, out_valid=0, in_ready=1 once rst_n=1.
REQ-034 SHALL cover counter saturation: CNT_W=2, five operands of 64'h1 (fifth last) -> out_sum=5, out_count=3.
